// File: rtl/arbitro_rr4_pkg.sv
// Shared definitions for the 4-source round-robin arbiter: FSM encoding,
// source/select widths and the rotating-priority winner scan.
package arbitro_rr4_pkg;

  localparam int N_SRC = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First requester found scanning start, start+1, ... with wrap 3->0.
  function automatic pick_t rr_pick(input logic [N_SRC-1:0] req,
                                    input logic [SEL_W-1:0] start);
    pick_t            p;
    logic [SEL_W-1:0] cand;
    p = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = start + SEL_W'(k);
      if (!p.found && req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/arbitro_rr4_if.sv
// Requester/consumer side of the arbiter: requests and data bits in,
// grant, select, busy and the muxed channel bit out.
interface arbitro_rr4_if;
   import arbitro_rr4_pkg::*;

   logic [N_SRC-1:0] req;
   logic [N_SRC-1:0] din;
   logic [N_SRC-1:0] grant;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic             dout;

   modport master (
      output req, din,
      input  grant, sel, busy, dout
   );

   modport slave (
      input  req, din,
      output grant, sel, busy, dout
   );

endinterface

// File: rtl/arbitro_rr4_mux4_1.sv
// Plain 4:1 bit multiplexer for the shared channel; gating by busy is done
// by the arbiter.
module arbitro_rr4_mux4_1
   import arbitro_rr4_pkg::*;
(
   input  logic [N_SRC-1:0] din,
   input  logic [SEL_W-1:0] sel,
   output logic             y
);

   assign y = din[sel];

endmodule

// File: rtl/arbitro_rr4.sv
// Round-robin arbiter with burst limit sharing one 1-bit channel among four
// sources; grant/sel/busy are registered, dout is combinational through the mux.
module arbitro_rr4
   import arbitro_rr4_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input logic          clk,
   input logic          rst_n,
   arbitro_rr4_if.slave bus
);

   localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   state_t            state;
   logic [N_SRC-1:0]  grant_q;
   logic [SEL_W-1:0]  sel_q;
   logic [SEL_W-1:0]  ptr;
   logic              busy_q;
   logic [HOLD_W-1:0] hold_cnt;

   logic              owner_req;
   logic              others_req;
   logic              hold_full;
   pick_t             idle_pick;
   pick_t             next_pick;
   logic              mux_raw;

   // NOTE: every signal is assigned on every pass of always_comb, so no latch is inferred.
   always_comb begin
      owner_req  = |(bus.req & grant_q);
      others_req = |(bus.req & ~grant_q);
      hold_full  = (hold_cnt == HOLD_MAX);
      idle_pick  = rr_pick(bus.req, ptr);
      // The owner is excluded so a forced rotation cannot re-pick it.
      next_pick  = rr_pick(bus.req & ~grant_q, sel_q + SEL_W'(1));
   end

   // NOTE: non-blocking assignments so every register reads pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         grant_q  <= '0;
         sel_q    <= '0;
         busy_q   <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (idle_pick.found) begin
                  state    <= ST_OWN;
                  grant_q  <= N_SRC'(1) << idle_pick.idx;
                  sel_q    <= idle_pick.idx;
                  busy_q   <= 1'b1;
                  hold_cnt <= HOLD_W'(1);
               end
            end

            ST_OWN: begin
               if (!owner_req || (hold_full && others_req)) begin
                  // Release or forced rotation: priority moves past the old owner.
                  ptr <= sel_q + SEL_W'(1);
                  if (next_pick.found) begin
                     grant_q  <= N_SRC'(1) << next_pick.idx;
                     sel_q    <= next_pick.idx;
                     hold_cnt <= HOLD_W'(1);
                  end else begin
                     state    <= ST_IDLE;
                     grant_q  <= '0;
                     busy_q   <= 1'b0;
                     hold_cnt <= '0;
                  end
               end else if (hold_full) begin
                  hold_cnt <= HOLD_W'(1);
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end

            default: begin
               state    <= ST_IDLE;
               grant_q  <= '0;
               busy_q   <= 1'b0;
               hold_cnt <= '0;
            end
         endcase
      end
   end

   arbitro_rr4_mux4_1 u_mux4_1 (
      .din (bus.din),
      .sel (sel_q),
      .y   (mux_raw)
   );

   assign bus.grant = grant_q;
   assign bus.sel   = sel_q;
   assign bus.busy  = busy_q;
   assign bus.dout  = busy_q & mux_raw;

endmodule

// File: tb/tb_arbitro_rr4.sv
// Directed bench for arbitro_rr4: a per-cycle behavioural model of owner,
// priority pointer and burst count, plus hand-computed literal checkpoints.
module tb_arbitro_rr4;

   localparam int MAX_HOLD = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   arbitro_rr4_if bus ();

   arbitro_rr4 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit run   = 1'b0;

   // Model state: current owner (-1 when free), priority start, cycles held.
   int         m_owner = -1;
   int         m_ptr   = 0;
   int         m_hold  = 0;
   int         m_sel   = 0;
   int         m_w;
   logic [3:0] m_others;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int winner(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner = -1;
         m_ptr   = 0;
         m_hold  = 0;
         m_sel   = 0;
      end else if (m_owner < 0) begin
         m_w = winner(bus.req, m_ptr);
         if (m_w >= 0) begin
            m_owner = m_w;
            m_sel   = m_w;
            m_hold  = 1;
         end
      end else begin
         m_others          = bus.req;
         m_others[m_owner] = 1'b0;
         if (!bus.req[m_owner] || (m_hold == MAX_HOLD && m_others != 4'b0000)) begin
            m_ptr   = (m_owner + 1) % 4;
            m_w     = winner(m_others, m_ptr);
            m_owner = m_w;
            if (m_w >= 0) begin
               m_sel  = m_w;
               m_hold = 1;
            end else begin
               m_hold = 0;
            end
         end else begin
            m_hold = (m_hold == MAX_HOLD) ? 1 : m_hold + 1;
         end
      end
   end

   // Compare process: every cycle once the first reset edge has been seen.
   always @(negedge clk) begin
      if (run) begin
         check("m_grant", {4'b0, bus.grant}, (m_owner < 0) ? 8'd0 : 8'(1 << m_owner));
         check("m_sel",   {6'b0, bus.sel},   8'(m_sel));
         check("m_busy",  {7'b0, bus.busy},  {7'b0, m_owner >= 0});
         check("m_dout",  {7'b0, bus.dout},  {7'b0, (m_owner >= 0) && bus.din[m_sel]});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic b);
      check({tag, "_grant"}, {4'b0, bus.grant}, {4'b0, g});
      check({tag, "_sel"},   {6'b0, bus.sel},   {6'b0, s});
      check({tag, "_busy"},  {7'b0, bus.busy},  {7'b0, b});
   endtask

   initial begin
      bus.req = 4'b0000;
      bus.din = 4'b0000;
      rst_n   = 1'b0;
      tick();
      run = 1'b1;

      // Reset held with everyone requesting.
      bus.req = 4'b1111;
      bus.din = 4'b1111;
      tick();
      expect_out("rst1", 4'b0000, 2'd0, 1'b0);
      check("rst1_dout", {7'b0, bus.dout}, 8'd0);
      tick();
      expect_out("rst2", 4'b0000, 2'd0, 1'b0);

      // Single request, one-cycle latency, then release to idle.
      rst_n   = 1'b1;
      bus.req = 4'b0100;
      bus.din = 4'b0100;
      tick();
      expect_out("grant2", 4'b0100, 2'd2, 1'b1);
      check("grant2_dout", {7'b0, bus.dout}, 8'd1);
      bus.req = 4'b0000;
      tick();
      expect_out("rel2", 4'b0000, 2'd2, 1'b0);
      check("rel2_dout", {7'b0, bus.dout}, 8'd0);

      // Pointer now 3: source 3 beats source 0.
      bus.req = 4'b1001;
      tick();
      expect_out("ptr3", 4'b1000, 2'd3, 1'b1);

      // Owner 3 drops while 0 is asking: wrap to source 0.
      bus.req = 4'b0001;
      tick();
      expect_out("wrap", 4'b0001, 2'd0, 1'b1);
      bus.req = 4'b0000;
      tick();
      expect_out("idle", 4'b0000, 2'd0, 1'b0);

      // Full load from a fresh reset: 0,1,2,3,0 each for MAX_HOLD cycles.
      rst_n = 1'b0;
      tick();
      rst_n   = 1'b1;
      bus.req = 4'b1111;
      bus.din = 4'b1010;
      for (int i = 0; i < 5; i++) begin
         for (int c = 0; c < MAX_HOLD; c++) begin
            tick();
            expect_out("burst", 4'(1 << (i % 4)), 2'(i % 4), 1'b1);
         end
      end

      // Lone requester keeps the channel past the burst limit.
      bus.req = 4'b0010;
      for (int i = 0; i < 20; i++) begin
         bus.din = 4'(i);
         tick();
         expect_out("solo", 4'b0010, 2'd1, 1'b1);
      end

      // Reset in the middle of a grant, then restart from pointer 0.
      bus.req = 4'b0100;
      tick();
      expect_out("pre_rst", 4'b0100, 2'd2, 1'b1);
      rst_n = 1'b0;
      tick();
      expect_out("mid_rst", 4'b0000, 2'd0, 1'b0);
      rst_n   = 1'b1;
      bus.req = 4'b0110;
      tick();
      expect_out("post_rst", 4'b0010, 2'd1, 1'b1);

      // Two contenders: owner 1 is forced out after MAX_HOLD cycles.
      bus.req = 4'b1010;
      bus.din = 4'b1000;
      repeat (MAX_HOLD - 1) tick();
      expect_out("hold_max", 4'b0010, 2'd1, 1'b1);
      tick();
      expect_out("rotate", 4'b1000, 2'd3, 1'b1);
      check("rotate_dout", {7'b0, bus.dout}, 8'd1);
      repeat (12) tick();

      bus.req = 4'b0000;
      tick();
      tick();
      run = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
